// File: rtl/sipo_deser_pkg.sv
// Shared constants and types for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam bit MSB_FIRST_ORDER = 1'b1;
    localparam bit LSB_FIRST_ORDER = 1'b0;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Ceiling log2, never below 1 so a counter is always at least one bit wide.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sipo_deser.sv
// Parametrised SIPO deserializer with a one-word output register, valid/ready
// handshake and sticky overflow when a completed word finds the register busy.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int  WIDTH     = DEFAULT_WIDTH,
    parameter bit  MSB_FIRST = MSB_FIRST_ORDER,
    localparam int CNT_W     = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic [WIDTH-1:0] pout_data,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             load_word;
    logic             drop_word;
    out_state_t       state_q;
    out_state_t       state_d;

    // The completed word is the post-shift value, so it includes the current bit.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {shift_reg[WIDTH-2:0], sin_data};
        end else begin : g_lsb_first
            assign shifted = {sin_data, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    assign complete   = sin_valid && (bit_cnt == LAST_CNT);
    assign pout_valid = (state_q == OUT_FULL);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state_q;
        load_word = 1'b0;
        drop_word = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (complete) begin
                    state_d   = OUT_FULL;
                    load_word = 1'b1;
                end
            end
            OUT_FULL: begin
                if (pout_ready) begin
                    load_word = complete;
                    state_d   = complete ? OUT_FULL : OUT_EMPTY;
                end else if (complete) begin
                    drop_word = 1'b1;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OUT_EMPTY;
            shift_reg <= '0;
            pout_data <= '0;
            bit_cnt   <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            state_q   <= OUT_EMPTY;
            shift_reg <= '0;
            pout_data <= '0;
            bit_cnt   <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sin_valid) begin
                shift_reg <= shifted;
                bit_cnt   <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + CNT_W'(1);
            end
            if (load_word) begin
                pout_data <= shifted;
            end
            if (drop_word) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus and
// are compared every cycle against a bit-list reference model.
module tb_sipo_deser;
    import sipo_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_data = 1'b0;
    logic         pout_ready = 1'b0;
    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l;
    logic [2:0]   cnt_m, cnt_l;
    logic         ovf_m, ovf_l;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: bits of the word in progress, in arrival order.
    bit           bits_q[$];
    bit           m_valid;
    bit           m_overflow;
    logic [W-1:0] m_data_m, m_data_l;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(MSB_FIRST_ORDER)) dut_msb (
        .clk(clk), .rst(rst), .clr(clr), .sin_valid(sin_valid), .sin_data(sin_data),
        .pout_data(data_m), .pout_valid(valid_m), .pout_ready(pout_ready),
        .bit_cnt(cnt_m), .overflow(ovf_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(LSB_FIRST_ORDER)) dut_lsb (
        .clk(clk), .rst(rst), .clr(clr), .sin_valid(sin_valid), .sin_data(sin_data),
        .pout_data(data_l), .pout_valid(valid_l), .pout_ready(pout_ready),
        .bit_cnt(cnt_l), .overflow(ovf_l)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input bit msb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) w[W-1-i] = bits_q[i];
            else           w[i]     = bits_q[i];
        end
        return w;
    endfunction

    task automatic model_clear();
        bits_q.delete();
        m_valid    = 1'b0;
        m_overflow = 1'b0;
        m_data_m   = '0;
        m_data_l   = '0;
    endtask

    task automatic model_edge();
        bit done;
        done = 1'b0;
        if (clr) begin
            model_clear();
        end else begin
            if (sin_valid) begin
                bits_q.push_back(sin_data);
                if (bits_q.size() == W) done = 1'b1;
            end
            if (done) begin
                if (!m_valid || pout_ready) begin
                    m_data_m = word_of(1'b1);
                    m_data_l = word_of(1'b0);
                    m_valid  = 1'b1;
                end else begin
                    m_overflow = 1'b1;
                end
                bits_q.delete();
            end else if (m_valid && pout_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("valid_msb", valid_m, m_valid);
        check("valid_lsb", valid_l, m_valid);
        check("ovf_msb", ovf_m, m_overflow);
        check("ovf_lsb", ovf_l, m_overflow);
        check("cnt_msb", cnt_m, bits_q.size());
        check("cnt_lsb", cnt_l, bits_q.size());
        if (m_valid) begin
            check("data_msb", data_m, m_data_m);
            check("data_lsb", data_l, m_data_l);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic rdy, input logic c);
        sin_valid  = v;
        sin_data   = d;
        pout_ready = rdy;
        clr        = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Sends val MSB first on the line; rdy_last applies to the final bit only.
    task automatic send_word(input logic [W-1:0] val, input logic rdy_rest, input logic rdy_last);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, val[i], (i == 0) ? rdy_last : rdy_rest, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_m"}, data_m, 0);
        check({tag, "_data_l"}, data_l, 0);
        check({tag, "_valid"}, valid_m, 0);
        check({tag, "_cnt"}, cnt_m, 0);
        check({tag, "_ovf"}, ovf_m, 0);
    endtask

    initial begin
        model_clear();
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();

        // Plain word, consumer always ready.
        send_word(8'h1E, 1'b1, 1'b1);
        check("word_msb_1e", data_m, 8'h1E);
        check("word_lsb_78", data_l, 8'h78);
        check("word_cnt_wrap", cnt_m, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("valid_one_cycle", valid_m, 0);

        // Same bits with idle gaps; model checks bit_cnt holds through them.
        for (int i = W - 1; i >= 0; i--) begin
            int gaps;
            logic [W-1:0] pat;
            pat  = 8'h1E;
            gaps = int'($urandom_range(3, 0));
            for (int g = 0; g < gaps; g++) step(1'b0, 1'($urandom), 1'b1, 1'b0);
            step(1'b1, pat[i], 1'b1, 1'b0);
        end
        check("gap_msb_1e", data_m, 8'h1E);
        check("gap_lsb_78", data_l, 8'h78);

        // Second word dropped while the first is still pending.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        check("ovf_data_held", data_m, 8'h11);
        check("ovf_valid", valid_m, 1);
        check("ovf_set", ovf_m, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_drain", valid_m, 0);
        check("ovf_sticky", ovf_m, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", ovf_m, 0);

        // Drain and completion on the same edge: no bubble, no overflow.
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b1);
        check("b2b_data", data_m, 8'h22);
        check("b2b_valid", valid_m, 1);
        check("b2b_ovf", ovf_m, 0);

        // Asynchronous reset mid-word, then a clean word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        send_word(8'hA5, 1'b1, 1'b1);
        check("rst_a5", data_m, 8'hA5);

        // Synchronous flush mid-word, then a clean word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_zero("sync_clr");
        send_word(8'hA5, 1'b1, 1'b1);
        check("clr_a5", data_m, 8'hA5);

        // Randomized traffic with back-pressure and occasional flushes.
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(3, 0) != 0), 1'($urandom),
                 1'($urandom_range(2, 0) != 0), 1'($urandom_range(99, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
